apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Two-requester arbiter in front of the APB_Master internal interface (transfer/ready/addr/wdata/write/rdata). It lets the RV32I core and a second bus master, such as a future DMA or debug port, share the single APB bus and its peripherals (RAM, GPO, GPI, GPIOC/D, FND).
- Each requester's single-cycle transfer pulse is captured into a pending slot.
- One winner per transaction is chosen round-robin.
- Address, write data and direction are held stable toward APB_Master until ready.
- Completion is routed back to the owning requester only.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- PCLK  in  1  bus clock
- PRESET  in  1  reset; synchronous, active-high
- m0_transfer  in  1  requester 0 start pulse (core)
- m0_addr  in  AW  requester 0 address
- m0_wdata  in  DW  requester 0 write data
- m0_write  in  1  requester 0 direction: 1 write, 0 read
- m0_ready  out  1  requester 0 completion pulse
- m0_rdata  out  DW  requester 0 read data
- m1_transfer, m1_addr, m1_wdata, m1_write, m1_ready, m1_rdata: same as m0_*, for requester 1
- transfer  out  1  start pulse to APB_Master
- addr  out  AW  address to APB_Master
- wdata  out  DW  write data to APB_Master
- write  out  1  direction to APB_Master
- ready  in  1  completion from APB_Master
- rdata  in  DW  read data from APB_Master
- grant  out  2  one-hot current owner; 00 when idle

## Operation
Pending slots (one per requester):
- A transfer pulse sets pending and captures addr, wdata and write.
- A pulse while the slot is already pending is ignored; the captured fields are not overwritten.

FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any slot is pending, select the owner and go to ISSUE.
- ISSUE: transfer=1 for exactly one cycle, then go to WAIT.
- WAIT: hold addr, wdata and write from the owner's slot. On ready=1:
  - assert m<owner>_ready=1 combinationally;
  - clear the owner's slot;
  - update last_grant;
  - go to IDLE.

Selection:
- Only one pending: that requester wins.
- Both pending: the requester not equal to last_grant wins.

Outputs:
- grant reflects the owner in ISSUE and WAIT, and is 00 in IDLE.
- The non-owner's m_ready is 0.
- m0_rdata and m1_rdata both carry rdata.
- addr, wdata and write are 0 in IDLE.

## Timing
- Reset values:
  - state=IDLE; both slots cleared.
  - last_grant=1, so requester 0 wins the first tie.
  - transfer, m0_ready, m1_ready = 0; grant=00; addr, wdata, write = 0.
- Latency: m_transfer at cycle 0 → pending at 1 (IDLE selects) → transfer=1 at cycle 2. Overhead is 2 cycles plus APB_Master latency; ready is returned with zero added cycles.
- Back-to-back: after completion in cycle N, IDLE is in N+1 and the next transfer is in N+2.
- Simultaneous capture and clear on one slot (a new pulse in the same cycle as its ready): set wins, so the new request is pending.
- Both requesters pulsing in the same cycle: both are captured, and the arbitration rule decides.
- Reset mid-transaction: everything returns to the reset values at the next edge. The outstanding request is dropped and no m_ready is issued.

## Configuration
- ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins ties. last_grant is not used for selection (the register may be removed).
- ARB_FIXED_PRIO_EN undefined: round-robin as described above.

## Structure
- Shared package apb_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, ISSUE, WAIT};
  - constants M0_ID=0, M1_ID=1;
  - GRANT_NONE=2'b00.
- Sub-module apb_arb_req_slot: pending flag plus captured addr/wdata/write, with set-over-clear semantics. It is instantiated twice.

## Test plan
1. Single read: m0 read 0x1000_0000 (GPI), ready returned 2 cycles after transfer with rdata=0x0000_00A5 → transfer at cycle 2, m0_ready=1 with m0_rdata=0xA5, grant=01 during the transaction, m1_ready stays 0.
2. Simultaneous tie after reset: m0 write 0x1000_2000 ← 0x0F and m1 read 0x1000_3000 in the same cycle → m0 served first, then m1 transfer two cycles after m0_ready, grant 01 then 10.
3. Round-robin fairness: both requesters re-request on every completion for 6 transactions → grant sequence 01,10,01,10,01,10. With ARB_FIXED_PRIO_EN defined the sequence is all 01 while m0 keeps requesting.
4. Hold stability: APB ready delayed 5 cycles while m1 pulses again with new addr 0x1000_4000 → addr, wdata and write stay at m0's values, and m1's slot keeps its first captured request.
5. Set-over-clear: m0 pulses a new request in its own ready cycle → m0 pending=1 afterwards, and a second m0 transfer is issued.
6. Reset in WAIT: assert PRESET for 1 cycle during WAIT → next cycle state=IDLE, grant=00, no m_ready, pending cleared.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and constants for the two-requester APB arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT)
//   M0_ID/M1_ID : requester identifiers (core / second bus master)
//   GRANT_NONE  : grant value while no requester owns the bus
//   id_to_grant : requester id -> one-hot grant vector
// ---------------------------------------------------------------------------
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic       M0_ID      = 1'b0;
  localparam logic       M1_ID      = 1'b1;
  localparam logic [1:0] GRANT_NONE = 2'b00;

  // One-hot grant for a requester id: bit 0 = requester 0, bit 1 = requester 1.
  function automatic logic [1:0] id_to_grant(input logic id);
    logic [1:0] g;
    case (id)
      M0_ID:   g = 2'b01;
      M1_ID:   g = 2'b10;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/apb_arb_req_slot.sv
// ---------------------------------------------------------------------------
// apb_arb_req_slot
// One pending-request slot: captures a requester's single-cycle transfer
// pulse together with its address, write data and direction, and holds them
// until the arbiter retires the request.
//   clk, rst       : clock, synchronous active-high reset
//   set            : requester transfer pulse
//   clr            : retire the held request (its completion cycle)
//   req_addr/req_wdata/req_write : request fields sampled on an accepted set
//   pending        : a request is held
//   slot_addr/slot_wdata/slot_write : held request fields
// A pulse arriving while a request is held is dropped, except in the cycle
// the held request is retired: then the new request replaces it (set wins).
// ---------------------------------------------------------------------------
module apb_arb_req_slot #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set,
  input  logic          clr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic          req_write,
  output logic          pending,
  output logic [AW-1:0] slot_addr,
  output logic [DW-1:0] slot_wdata,
  output logic          slot_write
);
  import apb_arb_pkg::*;

  logic          pending_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          write_r;
  logic          accept_s;

  // A pulse is accepted when the slot is empty or is being retired this cycle.
  always_comb begin
    accept_s = 1'b0;
    if (set && (!pending_r || clr)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Slot storage: capture on accept, drop pending on retire, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= 1'b0;
      addr_r    <= {AW{1'b0}};
      wdata_r   <= {DW{1'b0}};
      write_r   <= 1'b0;
    end else if (accept_s) begin
      pending_r <= 1'b1;
      addr_r    <= req_addr;
      wdata_r   <= req_wdata;
      write_r   <= req_write;
    end else if (clr) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  assign pending    = pending_r;
  assign slot_addr  = addr_r;
  assign slot_wdata = wdata_r;
  assign slot_write = write_r;

endmodule

// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
// Two-requester arbiter in front of the APB_Master internal interface. The
// RV32I core (requester 0) and a second bus master (requester 1) share one
// APB bus. Each requester's transfer pulse is latched in a pending slot; one
// owner per transaction is chosen, a single transfer pulse is issued, the
// owner's addr/wdata/write are held until ready, and ready is routed back to
// the owner only, with no added cycle.
//
// Ports:
//   PCLK, PRESET          : bus clock, synchronous active-high reset
//   m0_* / m1_*           : requester side (transfer pulse, addr, wdata,
//                           write, ready pulse, rdata)
//   transfer/addr/wdata/write : request toward APB_Master (registered)
//   ready/rdata           : completion and read data from APB_Master
//   grant                 : one-hot owner, 2'b00 while idle (registered)
//
// Build option:
//   ARB_FIXED_PRIO_EN defined   -> requester 0 always wins a tie.
//   ARB_FIXED_PRIO_EN undefined -> round-robin; last_grant resets to
//                                  requester 1 so requester 0 wins the first tie.
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          m0_transfer,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_write,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_transfer,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_write,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  output logic          transfer,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  output logic          write,
  input  logic          ready,
  input  logic [DW-1:0] rdata,
  output logic [1:0]    grant
);
  import apb_arb_pkg::*;

  arb_state_t    state_r;
  logic          owner_r;
  logic          transfer_r;
  logic [1:0]    grant_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          write_r;
`ifndef ARB_FIXED_PRIO_EN
  logic          last_grant_r;
`endif

  logic          pend0_s;
  logic          pend1_s;
  logic [AW-1:0] s0_addr_s;
  logic [AW-1:0] s1_addr_s;
  logic [DW-1:0] s0_wdata_s;
  logic [DW-1:0] s1_wdata_s;
  logic          s0_write_s;
  logic          s1_write_s;
  logic          any_pend_s;
  logic          sel_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;
  logic          sel_write_s;
  logic          done_s;
  logic          clr0_s;
  logic          clr1_s;

  apb_arb_req_slot #(.AW(AW), .DW(DW)) u_slot0 (
    .clk        (PCLK),
    .rst        (PRESET),
    .set        (m0_transfer),
    .clr        (clr0_s),
    .req_addr   (m0_addr),
    .req_wdata  (m0_wdata),
    .req_write  (m0_write),
    .pending    (pend0_s),
    .slot_addr  (s0_addr_s),
    .slot_wdata (s0_wdata_s),
    .slot_write (s0_write_s)
  );

  apb_arb_req_slot #(.AW(AW), .DW(DW)) u_slot1 (
    .clk        (PCLK),
    .rst        (PRESET),
    .set        (m1_transfer),
    .clr        (clr1_s),
    .req_addr   (m1_addr),
    .req_wdata  (m1_wdata),
    .req_write  (m1_write),
    .pending    (pend1_s),
    .slot_addr  (s1_addr_s),
    .slot_wdata (s1_wdata_s),
    .slot_write (s1_write_s)
  );

  // Winner selection among pending slots.
  always_comb begin
    any_pend_s = pend0_s | pend1_s;
    sel_s      = M0_ID;
`ifdef ARB_FIXED_PRIO_EN
    if (pend0_s) begin
      sel_s = M0_ID;
    end else begin
      sel_s = M1_ID;
    end
`else
    // On a tie the requester that did not win last time goes next.
    if (pend0_s && pend1_s) begin
      sel_s = ~last_grant_r;
    end else if (pend0_s) begin
      sel_s = M0_ID;
    end else begin
      sel_s = M1_ID;
    end
`endif
  end

  // Request fields of the selected slot, loaded into the output registers.
  always_comb begin
    sel_addr_s  = s0_addr_s;
    sel_wdata_s = s0_wdata_s;
    sel_write_s = s0_write_s;
    if (sel_s == M1_ID) begin
      sel_addr_s  = s1_addr_s;
      sel_wdata_s = s1_wdata_s;
      sel_write_s = s1_write_s;
    end else begin
      sel_addr_s  = s0_addr_s;
      sel_wdata_s = s0_wdata_s;
      sel_write_s = s0_write_s;
    end
  end

  // Completion decode: ready is passed straight through to the owner. It is
  // suppressed while reset is asserted so an aborted request never completes.
  always_comb begin
    done_s = 1'b0;
    clr0_s = 1'b0;
    clr1_s = 1'b0;
    if ((state_r == WAIT) && ready && !PRESET) begin
      done_s = 1'b1;
      clr0_s = (owner_r == M0_ID);
      clr1_s = (owner_r == M1_ID);
    end else begin
      done_s = 1'b0;
      clr0_s = 1'b0;
      clr1_s = 1'b0;
    end
  end

  // Arbitration FSM: pick an owner, issue one transfer pulse, hold until ready.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r    <= IDLE;
      owner_r    <= M0_ID;
      transfer_r <= 1'b0;
      grant_r    <= GRANT_NONE;
      addr_r     <= {AW{1'b0}};
      wdata_r    <= {DW{1'b0}};
      write_r    <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_r <= M1_ID;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (any_pend_s) begin
            state_r    <= ISSUE;
            owner_r    <= sel_s;
            transfer_r <= 1'b1;
            grant_r    <= id_to_grant(sel_s);
            addr_r     <= sel_addr_s;
            wdata_r    <= sel_wdata_s;
            write_r    <= sel_write_s;
          end else begin
            state_r    <= IDLE;
            transfer_r <= 1'b0;
            grant_r    <= GRANT_NONE;
            addr_r     <= {AW{1'b0}};
            wdata_r    <= {DW{1'b0}};
            write_r    <= 1'b0;
          end
        end
        ISSUE: begin
          state_r    <= WAIT;
          transfer_r <= 1'b0;
        end
        WAIT: begin
          transfer_r <= 1'b0;
          if (ready) begin
            state_r <= IDLE;
            grant_r <= GRANT_NONE;
            addr_r  <= {AW{1'b0}};
            wdata_r <= {DW{1'b0}};
            write_r <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant_r <= owner_r;
`endif
          end else begin
            state_r <= WAIT;
          end
        end
        default: begin
          state_r    <= IDLE;
          transfer_r <= 1'b0;
          grant_r    <= GRANT_NONE;
          addr_r     <= {AW{1'b0}};
          wdata_r    <= {DW{1'b0}};
          write_r    <= 1'b0;
        end
      endcase
    end
  end

  assign transfer = transfer_r;
  assign grant    = grant_r;
  assign addr     = addr_r;
  assign wdata    = wdata_r;
  assign write    = write_r;
  assign m0_ready = done_s & clr0_s;
  assign m1_ready = done_s & clr1_s;
  assign m0_rdata = rdata;
  assign m1_rdata = rdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          m0_transfer, m0_write, m0_ready;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_transfer, m1_write, m1_ready;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          transfer, write, ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic [1:0]    grant;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  bit model_on = 1'b0;

  // APB_Master stand-in parameters
  int          lat = 2;
  int          cnt = 0;
  logic [31:0] slave_rdata = 32'h0;

  apb_req_arbiter #(.AW(AW), .DW(DW)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .m0_transfer(m0_transfer), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_transfer(m1_transfer), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .transfer(transfer), .addr(addr), .wdata(wdata), .write(write),
    .ready(ready), .rdata(rdata), .grant(grant)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc_n <= cyc_n + 1;

  // APB_Master stand-in: ready 'lat' cycles after seeing transfer
  initial begin
    ready = 1'b0;
    rdata = 32'h0;
    forever begin
      @(posedge PCLK);
      #1;
      ready = 1'b0;
      rdata = 32'h0;
      if (PRESET) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          ready = 1'b1;
          rdata = slave_rdata;
        end
      end else if (transfer === 1'b1) begin
        cnt = lat;
      end
    end
  end

  // Transaction-level model: who owns the bus, in which cycle its transfer
  // was issued, and what each requester has outstanding.
  bit          mp   [2];
  logic [31:0] ma   [2];
  logic [31:0] mw   [2];
  logic        mwr  [2];
  int          mown = -1;
  int          miss = 0;
  int          mlast = 1;

  initial begin : model
    bit          p [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic        pw [2];
    bit          done_b;
    int          win;
    logic        e_tr, e_wr, e_r0, e_r1;
    logic [1:0]  e_gr;
    logic [31:0] e_addr, e_wd;
    forever begin
      @(negedge PCLK);
      e_tr   = (mown >= 0) && (cyc_n == miss);
      e_gr   = (mown < 0) ? 2'b00 : ((mown == 0) ? 2'b01 : 2'b10);
      e_addr = (mown < 0) ? 32'h0 : ma[mown];
      e_wd   = (mown < 0) ? 32'h0 : mw[mown];
      e_wr   = (mown < 0) ? 1'b0 : mwr[mown];
      done_b = (mown >= 0) && (cyc_n > miss) && (ready === 1'b1) && (PRESET === 1'b0);
      e_r0   = done_b && (mown == 0);
      e_r1   = done_b && (mown == 1);
      if (model_on) begin
        n_cmp++;
        if (transfer !== e_tr || grant !== e_gr || addr !== e_addr || wdata !== e_wd ||
            write !== e_wr || m0_ready !== e_r0 || m1_ready !== e_r1 ||
            m0_rdata !== rdata || m1_rdata !== rdata) begin
          n_bad++;
          $display("FAIL model_cyc%0d: got tr=%b gnt=%b addr=%h wd=%h wr=%b r0=%b r1=%b rd0=%h rd1=%h; required tr=%b gnt=%b addr=%h wd=%h wr=%b r0=%b r1=%b rd=%h",
                   cyc_n, transfer, grant, addr, wdata, write, m0_ready, m1_ready, m0_rdata, m1_rdata,
                   e_tr, e_gr, e_addr, e_wd, e_wr, e_r0, e_r1, rdata);
        end
      end
      // advance to the state after this cycle's clock edge
      if (PRESET === 1'b1) begin
        for (int r = 0; r < 2; r++) begin
          mp[r] = 1'b0; ma[r] = 32'h0; mw[r] = 32'h0; mwr[r] = 1'b0;
        end
        mown  = -1;
        mlast = 1;
      end else begin
        p[0] = m0_transfer; pa[0] = m0_addr; pd[0] = m0_wdata; pw[0] = m0_write;
        p[1] = m1_transfer; pa[1] = m1_addr; pd[1] = m1_wdata; pw[1] = m1_write;
        win = -1;
        if (mown < 0 && (mp[0] || mp[1])) begin
`ifdef ARB_FIXED_PRIO_EN
          win = mp[0] ? 0 : 1;
`else
          if (mp[0] && mp[1]) win = (mlast == 0) ? 1 : 0;
          else win = mp[0] ? 0 : 1;
`endif
        end
        for (int r = 0; r < 2; r++) begin
          if (p[r] && (!mp[r] || (done_b && mown == r))) begin
            mp[r] = 1'b1; ma[r] = pa[r]; mw[r] = pd[r]; mwr[r] = pw[r];
          end else if (done_b && mown == r) begin
            mp[r] = 1'b0;
          end
        end
        if (done_b) begin
          mlast = mown;
          mown  = -1;
        end else if (win >= 0) begin
          mown = win;
          miss = cyc_n + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #2;
    m0_transfer = 1'b0;
    m1_transfer = 1'b0;
  endtask

  task automatic pulse(input int r, input logic [31:0] a, input logic [31:0] d, input logic w);
    if (r == 0) begin
      m0_transfer = 1'b1; m0_addr = a; m0_wdata = d; m0_write = w;
    end else begin
      m1_transfer = 1'b1; m1_addr = a; m1_wdata = d; m1_write = w;
    end
  endtask

  task automatic reset_dut();
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
  endtask

  // which: 0 transfer, 1 m0_ready, 2 m1_ready, 3 either ready
  task automatic wait_sig(input int which, input string nm, output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if ((which == 0 && transfer === 1'b1) || (which == 1 && m0_ready === 1'b1) ||
          (which == 2 && m1_ready === 1'b1) ||
          (which == 3 && (m0_ready === 1'b1 || m1_ready === 1'b1))) begin
        at = cyc_n;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: got no event within 60 cycles, required one", nm);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int c0, t0, t1, r0, r1;
    logic [1:0] seq     [6];
    logic [1:0] exp_seq [6];
    logic [31:0] g;
`ifdef ARB_FIXED_PRIO_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01;
    exp_seq[3] = 2'b01; exp_seq[4] = 2'b01; exp_seq[5] = 2'b01;
`else
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
    exp_seq[3] = 2'b10; exp_seq[4] = 2'b01; exp_seq[5] = 2'b10;
`endif
    PRESET = 1'b1;
    m0_transfer = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_write = 1'b0;
    m1_transfer = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_write = 1'b0;
    repeat (2) step();
    PRESET = 1'b0;
    model_on = 1'b1;

    // reset state
    chk("rst_grant", {30'h0, grant}, 32'h0);
    chk("rst_transfer", {31'h0, transfer}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_ready", {30'h0, m1_ready, m0_ready}, 32'h0);

    // 1: single m0 read of GPI
    lat = 2; slave_rdata = 32'h0000_00A5;
    step();
    c0 = cyc_n;
    pulse(0, 32'h1000_0000, 32'h0, 1'b0);
    wait_sig(0, "t1_transfer", t0);
    chk("t1_transfer_cycle", t0 - c0, 32'd2);
    chk("t1_grant", {30'h0, grant}, 32'h1);
    wait_sig(1, "t1_ready", r0);
    chk("t1_ready_delay", r0 - t0, 32'd2);
    chk("t1_rdata", m0_rdata, 32'h0000_00A5);
    chk("t1_m1_ready", {31'h0, m1_ready}, 32'h0);
    repeat (3) step();

    // 2: simultaneous tie after reset
    reset_dut();
    slave_rdata = 32'h0000_005A;
    pulse(0, 32'h1000_2000, 32'h0000_000F, 1'b1);
    pulse(1, 32'h1000_3000, 32'h0, 1'b0);
    wait_sig(0, "t2_tr0", t0);
    chk("t2_grant0", {30'h0, grant}, 32'h1);
    chk("t2_addr0", addr, 32'h1000_2000);
    chk("t2_wdata0", wdata, 32'h0000_000F);
    chk("t2_write0", {31'h0, write}, 32'h1);
    wait_sig(1, "t2_rdy0", r0);
    wait_sig(0, "t2_tr1", t1);
    chk("t2_gap", t1 - r0, 32'd2);
    chk("t2_grant1", {30'h0, grant}, 32'h2);
    chk("t2_addr1", addr, 32'h1000_3000);
    wait_sig(2, "t2_rdy1", r1);
    chk("t2_rdata1", m1_rdata, 32'h0000_005A);
    repeat (3) step();

    // 3: fairness with both requesters always re-requesting
    reset_dut();
    slave_rdata = 32'h1234_5678;
    pulse(0, 32'h1000_0000, 32'h0, 1'b0);
    pulse(1, 32'h1000_1000, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      wait_sig(0, "t3_tr", t0);
      seq[k] = grant;
      wait_sig(3, "t3_rdy", r0);
      if (m0_ready === 1'b1) pulse(0, 32'h1000_0000 + k, 32'h0, 1'b0);
      else pulse(1, 32'h1000_1000 + k, 32'h0, 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      g = {30'h0, seq[k]};
      chk($sformatf("t3_seq%0d", k), g, {30'h0, exp_seq[k]});
    end
    repeat (20) step();

    // 4: hold stability under a slow APB completion
    reset_dut();
    lat = 5; slave_rdata = 32'h0;
    pulse(0, 32'h1000_0100, 32'h0000_0011, 1'b1);
    pulse(1, 32'h1000_3004, 32'h0000_0000, 1'b0);
    wait_sig(0, "t4_tr0", t0);
    step();
    pulse(1, 32'h1000_4000, 32'h0000_0022, 1'b1);
    wait_sig(1, "t4_rdy0", r0);
    chk("t4_delay", r0 - t0, 32'd5);
    chk("t4_hold_addr", addr, 32'h1000_0100);
    chk("t4_hold_wdata", wdata, 32'h0000_0011);
    chk("t4_hold_write", {31'h0, write}, 32'h1);
    wait_sig(0, "t4_tr1", t1);
    chk("t4_m1_addr", addr, 32'h1000_3004);
    chk("t4_m1_write", {31'h0, write}, 32'h0);
    wait_sig(2, "t4_rdy1", r1);
    repeat (3) step();

    // 5: new m0 pulse in its own ready cycle
    reset_dut();
    lat = 2;
    pulse(0, 32'h1000_0000, 32'h0, 1'b0);
    wait_sig(1, "t5_rdy0", r0);
    pulse(0, 32'h1000_0004, 32'h0, 1'b0);
    wait_sig(0, "t5_tr1", t1);
    chk("t5_gap", t1 - r0, 32'd2);
    chk("t5_addr", addr, 32'h1000_0004);
    chk("t5_grant", {30'h0, grant}, 32'h1);
    wait_sig(1, "t5_rdy1", r1);
    repeat (3) step();

    // 6: reset while waiting for ready
    reset_dut();
    lat = 20;
    pulse(1, 32'h1000_5000, 32'h0, 1'b0);
    wait_sig(0, "t6_tr", t0);
    step();
    step();
    chk("t6_grant_wait", {30'h0, grant}, 32'h2);
    reset_dut();
    chk("t6_grant", {30'h0, grant}, 32'h0);
    chk("t6_addr", addr, 32'h0);
    chk("t6_transfer", {31'h0, transfer}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_idle", {29'h0, transfer, m1_ready, m0_ready}, 32'h0);
    end
    lat = 2;
    pulse(0, 32'h1000_6000, 32'h0, 1'b0);
    wait_sig(0, "t6_after", t0);
    chk("t6_after_addr", addr, 32'h1000_6000);
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
